// File: rtl/bug_motion_ctl.sv
// Bug sprite motion sequencer: updates position/rotation once per frame at the
// rising edge of vertical blanking, with turn latching and wall bounce/pause.
module bug_motion_ctl #(
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 768,
  parameter int BUG_W       = 53,
  parameter int BUG_H       = 54,
  parameter int X_INIT      = 485,
  parameter int Y_INIT      = 357,
  parameter int STEP        = 2,
  parameter int TURN_FRAMES = 8
) (
  input  logic        i_pclk,
  input  logic        i_reset,
  input  logic        i_vblnk_in,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_turn_left,
  input  logic        i_turn_right,
  input  logic [1:0]  i_speed,
  output logic [11:0] o_x_bugpos,
  output logic [11:0] o_y_bugpos,
  output logic [1:0]  o_rotation,
  output logic        o_moving,
  output logic        o_wall_hit
);

  // state | meaning
  // IDLE  | stationary, turns still rotate in place at each frame tick
  // MOVE  | advance one step per frame tick in the facing direction
  // PAUSE | held still after a bounce for TURN_FRAMES ticks
  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_PAUSE} state_t;

  localparam logic signed [12:0] X_MAX = 13'(SCREEN_W - BUG_W);
  localparam logic signed [12:0] Y_MAX = 13'(SCREEN_H - BUG_H);

  state_t      r_state, w_state_n;
  logic        r_vblnk_q;
  logic        r_turn_vld, w_turn_vld_n;
  logic        r_turn_right, w_turn_right_n;
  logic [7:0]  r_pause_cnt, w_pause_cnt_n;
  logic [11:0] r_x, w_x_n;
  logic [11:0] r_y, w_y_n;
  logic [1:0]  r_rot, w_rot_n;
  logic        r_wall_hit, w_wall_hit_n;

  logic                w_tick;
  logic [1:0]          w_rot_turn;
  logic signed [12:0]  w_step;
  logic signed [12:0]  w_x_try, w_y_try;
  logic signed [12:0]  w_x_clamp, w_y_clamp;
  logic                w_hit;

  assign w_tick     = i_vblnk_in & ~r_vblnk_q;
  assign w_rot_turn = r_turn_vld ? (r_turn_right ? r_rot + 2'd1 : r_rot + 2'd3) : r_rot;
  assign w_step     = 13'(STEP) << i_speed;

  // Candidate position from the post-turn heading; only one axis moves.
  always_comb begin
    w_x_try = $signed({1'b0, r_x});
    w_y_try = $signed({1'b0, r_y});
    case (w_rot_turn)
      2'd0:    w_y_try = $signed({1'b0, r_y}) - w_step;
      2'd1:    w_x_try = $signed({1'b0, r_x}) + w_step;
      2'd2:    w_y_try = $signed({1'b0, r_y}) + w_step;
      default: w_x_try = $signed({1'b0, r_x}) - w_step;
    endcase
  end

  assign w_x_clamp = (w_x_try < 13'sd0) ? 13'sd0 : ((w_x_try > X_MAX) ? X_MAX : w_x_try);
  assign w_y_clamp = (w_y_try < 13'sd0) ? 13'sd0 : ((w_y_try > Y_MAX) ? Y_MAX : w_y_try);
  assign w_hit     = (w_x_clamp != w_x_try) || (w_y_clamp != w_y_try);

  always_comb begin
    w_state_n      = r_state;
    w_turn_vld_n   = r_turn_vld;
    w_turn_right_n = r_turn_right;
    w_pause_cnt_n  = r_pause_cnt;
    w_x_n          = r_x;
    w_y_n          = r_y;
    w_rot_n        = r_rot;
    w_wall_hit_n   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_n = S_MOVE;
        if (w_tick) begin
          w_rot_n      = w_rot_turn;
          w_turn_vld_n = 1'b0;
        end
      end
      S_MOVE: begin
        if (i_stop) begin
          w_state_n = S_IDLE;
        end else if (w_tick) begin
          w_turn_vld_n = 1'b0;
          w_x_n        = 12'(w_x_clamp);
          w_y_n        = 12'(w_y_clamp);
          if (w_hit) begin
            w_rot_n      = w_rot_turn + 2'd2;
            w_wall_hit_n = 1'b1;
            if (TURN_FRAMES != 0) begin
              w_pause_cnt_n = 8'(TURN_FRAMES);
              w_state_n     = S_PAUSE;
            end
          end else begin
            w_rot_n = w_rot_turn;
          end
        end
      end
      S_PAUSE: begin
        if (i_stop) begin
          w_state_n     = S_IDLE;
          w_pause_cnt_n = 8'd0;
        end else if (w_tick) begin
          w_pause_cnt_n = r_pause_cnt - 8'd1;
          if (r_pause_cnt <= 8'd1) w_state_n = S_MOVE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // A fresh pulse overrides the clear done at a tick; simultaneous L+R is ignored.
    if ((r_state != S_PAUSE) && (i_turn_left ^ i_turn_right)) begin
      w_turn_vld_n   = 1'b1;
      w_turn_right_n = i_turn_right;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_vblnk_q    <= 1'b0;
      r_turn_vld   <= 1'b0;
      r_turn_right <= 1'b0;
      r_pause_cnt  <= 8'd0;
      r_x          <= 12'(X_INIT);
      r_y          <= 12'(Y_INIT);
      r_rot        <= 2'd0;
      r_wall_hit   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_vblnk_q    <= i_vblnk_in;
      r_turn_vld   <= w_turn_vld_n;
      r_turn_right <= w_turn_right_n;
      r_pause_cnt  <= w_pause_cnt_n;
      r_x          <= w_x_n;
      r_y          <= w_y_n;
      r_rot        <= w_rot_n;
      r_wall_hit   <= w_wall_hit_n;
    end
  end

  assign o_x_bugpos = r_x;
  assign o_y_bugpos = r_y;
  assign o_rotation = r_rot;
  assign o_moving   = (r_state == S_MOVE);
  assign o_wall_hit = r_wall_hit;

endmodule

// File: tb/tb_bug_motion_ctl.sv
// Bench for bug_motion_ctl: directed scenarios plus randomized frames, every
// cycle compared against a per-frame arithmetic model of the sprite motion.
module tb_bug_motion_ctl;

  localparam int XMAX = 1024 - 53;
  localparam int YMAX = 768 - 54;
  localparam int TF   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblnk = 1'b0;
  logic        start = 1'b0, stop = 1'b0, tl = 1'b0, tr = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic [11:0] x_pos, y_pos;
  logic [1:0]  rot;
  logic        moving, wall_hit;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_x, m_y, m_rot, m_mode, m_cnt;
  bit m_pv, m_pr, m_vq, m_hit;
  int dxs[4] = '{0, 1, 0, -1};
  int dys[4] = '{-1, 0, 1, 0};

  bug_motion_ctl dut (
    .i_pclk(clk), .i_reset(rst_n), .i_vblnk_in(vblnk), .i_start(start), .i_stop(stop),
    .i_turn_left(tl), .i_turn_right(tr), .i_speed(speed),
    .o_x_bugpos(x_pos), .o_y_bugpos(y_pos), .o_rotation(rot),
    .o_moving(moving), .o_wall_hit(wall_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit vb, input bit st, input bit sp,
                            input bit l, input bit rr, input int spd);
    bit tick;
    int old_mode, step, nx, ny;
    if (!r) begin
      m_x = 485; m_y = 357; m_rot = 0; m_mode = 0; m_cnt = 0;
      m_pv = 0; m_pr = 0; m_vq = 0; m_hit = 0;
      return;
    end
    tick = vb && !m_vq;
    m_vq = vb;
    m_hit = 0;
    old_mode = m_mode;
    case (m_mode)
      0: begin
        if (st) m_mode = 1;
        if (tick) begin
          if (m_pv) m_rot = (m_rot + (m_pr ? 1 : 3)) % 4;
          m_pv = 0;
        end
      end
      1: begin
        if (sp) m_mode = 0;
        else if (tick) begin
          if (m_pv) m_rot = (m_rot + (m_pr ? 1 : 3)) % 4;
          m_pv = 0;
          step = 2 << spd;
          nx = m_x + dxs[m_rot] * step;
          ny = m_y + dys[m_rot] * step;
          if (nx < 0 || nx > XMAX || ny < 0 || ny > YMAX) begin
            m_x = (nx < 0) ? 0 : ((nx > XMAX) ? XMAX : nx);
            m_y = (ny < 0) ? 0 : ((ny > YMAX) ? YMAX : ny);
            m_rot = (m_rot + 2) % 4;
            m_hit = 1;
            m_mode = 2;
            m_cnt = TF;
          end else begin
            m_x = nx; m_y = ny;
          end
        end
      end
      default: begin
        if (sp) begin m_mode = 0; m_cnt = 0; end
        else if (tick) begin
          m_cnt--;
          if (m_cnt == 0) m_mode = 1;
        end
      end
    endcase
    if (old_mode != 2 && (l ^ rr)) begin m_pv = 1; m_pr = rr; end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit r, input bit vb, input bit st, input bit sp,
                     input bit l, input bit rr);
    logic [31:0] exp_v;
    rst_n = r; vblnk = vb; start = st; stop = sp; tl = l; tr = rr;
    model_step(r, vb, st, sp, l, rr, int'(speed));
    @(posedge clk);
    #1;
    exp_v = {4'd0, 12'(m_x), 12'(m_y), 2'(m_rot), (m_mode == 1), m_hit};
    check("cycle", {4'd0, x_pos, y_pos, rot, moving, wall_hit}, exp_v);
    start = 0; stop = 0; tl = 0; tr = 0;
  endtask

  task automatic frame();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
  endtask

  initial begin
    m_vq = 0;
    #2;
    // reset and idle frames
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_x", 32'(x_pos), 485);
    check("rst_y", 32'(y_pos), 357);
    check("rst_rot", 32'(rot), 0);
    check("rst_mov_hit", {30'd0, moving, wall_hit}, 0);
    for (int f = 0; f < 3; f++) frame();
    check("idle_pos", {8'd0, x_pos, y_pos}, {8'd0, 12'd485, 12'd357});
    check("idle_moving", 32'(moving), 0);

    // move up at base speed
    speed = 2'd0;
    cyc(1, 0, 1, 0, 0, 0);
    check("start_moving", 32'(moving), 1);
    for (int f = 0; f < 5; f++) frame();
    check("up5_y", 32'(y_pos), 347);
    check("up5_x", 32'(x_pos), 485);

    // turns
    cyc(1, 0, 0, 0, 0, 1);
    frame();
    check("turn_r_rot", 32'(rot), 1);
    check("turn_r_x", 32'(x_pos), 487);
    cyc(1, 0, 0, 0, 1, 1);
    frame();
    check("turn_both_rot", 32'(rot), 1);
    check("turn_both_x", 32'(x_pos), 489);

    // run right to x=969 then bounce at step 4
    speed = 2'd3;
    for (int f = 0; f < 30; f++) frame();
    check("pre_wall_x", 32'(x_pos), 969);
    speed = 2'd1;
    frame();
    check("wall_x", 32'(x_pos), 971);
    check("wall_rot", 32'(rot), 3);
    check("wall_hit_hi", 32'(wall_hit), 1);
    cyc(1, 0, 0, 0, 0, 0);
    check("wall_hit_lo", 32'(wall_hit), 0);
    check("pause_moving", 32'(moving), 0);
    for (int f = 0; f < 8; f++) begin
      frame();
      check("pause_hold_x", 32'(x_pos), 971);
    end
    frame();
    check("after_pause_x", 32'(x_pos), 967);

    // bounce off the left edge, stop during pause, restart
    speed = 2'd3;
    for (int f = 0; f < 61; f++) frame();
    check("left_wall_x", 32'(x_pos), 0);
    check("left_wall_rot", 32'(rot), 1);
    frame();
    frame();
    cyc(1, 0, 0, 1, 0, 0);
    check("stop_pause", 32'(moving), 0);
    cyc(1, 0, 1, 0, 0, 0);
    check("restart", 32'(moving), 1);
    frame();
    check("restart_x", 32'(x_pos), 16);
    cyc(1, 0, 1, 1, 0, 0);
    check("start_stop", 32'(moving), 0);

    // reset mid-move at x=600 with a pending turn
    cyc(1, 0, 1, 0, 0, 0);
    for (int f = 0; f < 36; f++) frame();
    speed = 2'd1;
    frame();
    frame();
    check("x600", 32'(x_pos), 600);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("mid_rst", {6'd0, x_pos, y_pos, rot, moving}, {6'd0, 12'd485, 12'd357, 2'd0, 1'b0});
    frame();
    check("pend_cleared", 32'(rot), 0);
    speed = 2'd0;
    cyc(1, 0, 1, 0, 0, 0);
    frame();
    check("post_rst_y", 32'(y_pos), 355);

    // randomized frames; pulses only while vblank is low
    for (int f = 0; f < 400; f++) begin
      int nlow;
      nlow = int'($urandom_range(2, 8));
      for (int i = 0; i < nlow; i++) begin
        int pick;
        bit r;
        pick = int'($urandom_range(0, 99));
        r = ($urandom_range(0, 499) != 0);
        speed = 2'($urandom_range(0, 3));
        cyc(r, 0, pick < 8, (pick >= 8 && pick < 11), (pick >= 11 && pick < 18) || pick == 25,
            (pick >= 18 && pick < 25) || pick == 25);
      end
      cyc(1, 1, 0, 0, 0, 0);
      if ($urandom_range(0, 1) == 1) cyc(1, 1, 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bug_motion_ctl.md
Name: bug_motion_ctl

Overview:
- Sequences the bug sprite: generates x_bugpos, y_bugpos and rotation for the sprite renderer, once per video frame.
- Position and rotation change only at the start of vertical blanking, so the sprite never tears mid-frame.
- Handles start/stop, left/right turn requests, speed selection and screen-edge bounce with a short pause.
- Sits between the game/keyboard logic and the sprite renderer, on the pclk domain.

Parameters:
SCREEN_W, 1024, visible width in pixels
SCREEN_H, 768, visible height in pixels
BUG_W, 53, sprite bounding-box width
BUG_H, 54, sprite bounding-box height
X_INIT, 485, reset x position
Y_INIT, 357, reset y position
STEP, 2, base pixels moved per frame
TURN_FRAMES, 8, frames held still after a wall hit

Ports:
pclk  in  1  pixel clock; all logic on its rising edge
reset  in  1  synchronous, active-low (0 = reset)
vblnk_in  in  1  vertical blanking from the timing chain
start  in  1  one-cycle pulse: begin moving
stop  in  1  one-cycle pulse: halt
turn_left  in  1  one-cycle pulse: rotate 90° counter-clockwise
turn_right  in  1  one-cycle pulse: rotate 90° clockwise
speed  in  2  step multiplier select: step = STEP << speed
x_bugpos  out  12  sprite left column
y_bugpos  out  12  sprite top row
rotation  out  2  00 = facing up, 01 = right, 10 = down, 11 = left
moving  out  1  1 in MOVE state
wall_hit  out  1  one-cycle pulse on a bounce

Behaviour:
Reset (reset==0 at a pclk edge):
- x_bugpos=X_INIT, y_bugpos=Y_INIT, rotation=00.
- moving=0, wall_hit=0.
- state=IDLE; pending turn cleared; pause counter=0; vblnk_q=0.
- Reset asserted mid-move has the same effect; no partial update survives it.

Frame tick:
- tick = vblnk_in & ~vblnk_q, where vblnk_q is vblnk_in registered.
- All position, rotation and counter updates happen only at the edge where tick=1.
- Outputs therefore change one pclk after vblnk_in rises.

Turn latch:
- A turn_left or turn_right pulse sets a pending turn (direction and valid bit). The latest pulse wins.
- turn_left and turn_right in the same cycle: both ignored, pending unchanged.
- Turn pulses arriving in PAUSE are discarded.

States:
- IDLE: moving=0. On start go to MOVE immediately. At tick, apply any pending turn (rotate in place), position unchanged.
- MOVE: moving=1. stop returns to IDLE immediately; stop beats start in the same cycle. At tick:
  1. Apply the pending turn first: right = rotation+1, left = rotation+3, modulo 4. Clear pending.
  2. Compute the step from the new rotation and current speed.
  3. Move: up = y-step, down = y+step, left = x-step, right = x+step.
- PAUSE: moving=0. Decrement the pause counter at each tick; go to MOVE at the tick where it reaches 0. stop goes to IDLE and clears the counter; start is ignored.

Arithmetic and bounds:
- Next position is computed in 13-bit signed.
- Limits: x in [0, SCREEN_W-BUG_W], y in [0, SCREEN_H-BUG_H].
- Landing exactly on a limit is legal and is not a hit.

Wall hit (next position outside its limit):
- Clamp to the limit and set rotation to rotation+2 (reverse).
- wall_hit=1 for exactly one pclk, coincident with the update.
- Load the pause counter with TURN_FRAMES and go to PAUSE.
- TURN_FRAMES=0 skips PAUSE and stays in MOVE.

Other outputs:
- speed is sampled at tick only.
- wall_hit=0 at all other times.

Test Plan:
- Reset release, no start, 3 vblank rising edges -> x=485, y=357, rotation=00, moving=0 throughout.
- start, speed=00, rotation 00, 5 ticks -> y=347, x=485, moving=1; each change lands 1 pclk after vblnk_in rises, never mid-line.
- turn_right pulse then tick -> rotation=01 and x=487 on that same tick; turn_left and turn_right in the same cycle -> rotation unchanged.
- Facing right, x=969, speed=01 (step 4) -> x clamped to 971, rotation=11, wall_hit high 1 cycle, x unchanged for 8 ticks, then x=967.
- stop during PAUSE -> IDLE, moving=0; later start -> MOVE with no residual pause; start and stop in the same cycle in MOVE -> IDLE.
- reset=0 for 1 cycle mid-MOVE at x=600 -> next cycle x=485, y=357, rotation=00, state IDLE, pending turn cleared.
